// File: rtl/ifu_fetch_pkg.sv
// Shared definitions for the instruction fetch unit: widths, reset vector and FSM encoding.
package ifu_fetch_pkg;

  localparam int unsigned IFU_ADDR_WIDTH   = 8;
  localparam int unsigned IFU_INST_WIDTH   = 8;
  localparam int unsigned IFU_RESET_VECTOR = 0;

  typedef enum logic [1:0] {
    IFU_ST_FETCH = 2'd0,
    IFU_ST_VALID = 2'd1,
    IFU_ST_DRAIN = 2'd2
  } ifu_state_e;

endpackage

// File: rtl/ifu_buf.sv
// One-entry data+valid holding register with load/clear; load wins over clear.
module ifu_buf #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             clear,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] data,
  output logic             valid
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data  <= '0;
      valid <= 1'b0;
    end else if (load) begin
      data  <= din;
      valid <= 1'b1;
    end else if (clear) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/ifu_fetch.sv
// Instruction fetch unit: PC, req/ack fetch FSM and fetched-byte register.
// Optional one-entry prefetch of pc+1 when IFU_PREFETCH_EN is defined.
module ifu_fetch
  import ifu_fetch_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH   = IFU_ADDR_WIDTH,
  parameter int unsigned INST_WIDTH   = IFU_INST_WIDTH,
  parameter int unsigned RESET_VECTOR = IFU_RESET_VECTOR
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  pc_count,
  input  logic                  pc_load,
  input  logic [ADDR_WIDTH-1:0] load_addr,
  output logic                  imem_req,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  input  logic                  imem_ack,
  input  logic [INST_WIDTH-1:0] imem_rdata,
  output logic [INST_WIDTH-1:0] imem_data,
  output logic                  fetch_valid,
  output logic                  stall,
  output logic [ADDR_WIDTH-1:0] pc
);

  localparam logic [ADDR_WIDTH-1:0] RST_PC = ADDR_WIDTH'(RESET_VECTOR);

  ifu_state_e            state, state_d;
  logic [ADDR_WIDTH-1:0] req_addr, req_addr_d, pc_d;
  logic [ADDR_WIDTH-1:0] pc_inc;
  logic                  out_load, out_clear;
  logic [INST_WIDTH-1:0] out_din;

  assign pc_inc = pc + ADDR_WIDTH'(1);

`ifdef IFU_PREFETCH_EN
  logic [ADDR_WIDTH-1:0] pc_inc2;
  logic                  pbuf_load, pbuf_clear, pbuf_valid;
  logic [INST_WIDTH-1:0] pbuf_data;

  assign pc_inc2 = pc + ADDR_WIDTH'(2);

  ifu_buf #(.WIDTH(INST_WIDTH)) u_pbuf (
    .clk   (clk),
    .rst   (rst),
    .load  (pbuf_load),
    .clear (pbuf_clear),
    .din   (imem_rdata),
    .data  (pbuf_data),
    .valid (pbuf_valid)
  );

  // In VALID the bus stays busy prefetching pc+1 until pbuf is filled.
  assign imem_req = rst && ((state != IFU_ST_VALID) || !pbuf_valid);
`else
  assign imem_req = rst && (state != IFU_ST_VALID);
`endif

  assign imem_addr = req_addr;
  assign stall     = ~fetch_valid;

  ifu_buf #(.WIDTH(INST_WIDTH)) u_out (
    .clk   (clk),
    .rst   (rst),
    .load  (out_load),
    .clear (out_clear),
    .din   (out_din),
    .data  (imem_data),
    .valid (fetch_valid)
  );

  // Next-state, PC/address update and buffer control decode.
  always_comb begin
    state_d    = state;
    pc_d       = pc;
    req_addr_d = req_addr;
    out_load   = 1'b0;
    out_clear  = 1'b0;
    out_din    = imem_rdata;
`ifdef IFU_PREFETCH_EN
    pbuf_load  = 1'b0;
    pbuf_clear = 1'b0;
`endif
    unique case (state)
      IFU_ST_FETCH: begin
        if (pc_load) begin
          pc_d = load_addr;
          if (imem_ack) req_addr_d = load_addr;
          else          state_d    = IFU_ST_DRAIN;
        end else if (imem_ack) begin
          out_load = 1'b1;
          state_d  = IFU_ST_VALID;
`ifdef IFU_PREFETCH_EN
          req_addr_d = pc_inc;
`endif
        end
      end
      IFU_ST_VALID: begin
`ifdef IFU_PREFETCH_EN
        if (pc_load) begin
          pc_d       = load_addr;
          out_clear  = 1'b1;
          pbuf_clear = 1'b1;
          // An unacked prefetch must complete on its old address first.
          if (!pbuf_valid && !imem_ack) begin
            state_d = IFU_ST_DRAIN;
          end else begin
            req_addr_d = load_addr;
            state_d    = IFU_ST_FETCH;
          end
        end else if (pc_count) begin
          pc_d = pc_inc;
          if (pbuf_valid) begin
            out_load   = 1'b1;
            out_din    = pbuf_data;
            pbuf_clear = 1'b1;
            req_addr_d = pc_inc2;
          end else if (imem_ack) begin
            out_load   = 1'b1;
            req_addr_d = pc_inc2;
          end else begin
            out_clear = 1'b1;
            state_d   = IFU_ST_FETCH;
          end
        end else if (!pbuf_valid && imem_ack) begin
          pbuf_load = 1'b1;
        end
`else
        if (pc_load) begin
          pc_d       = load_addr;
          req_addr_d = load_addr;
          out_clear  = 1'b1;
          state_d    = IFU_ST_FETCH;
        end else if (pc_count) begin
          pc_d       = pc_inc;
          req_addr_d = pc_inc;
          out_clear  = 1'b1;
          state_d    = IFU_ST_FETCH;
        end
`endif
      end
      IFU_ST_DRAIN: begin
        if (pc_load) pc_d = load_addr;
        if (imem_ack) begin
          req_addr_d = pc_d;
          state_d    = IFU_ST_FETCH;
        end
      end
      default: state_d = IFU_ST_FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IFU_ST_FETCH;
      pc       <= RST_PC;
      req_addr <= RST_PC;
    end else begin
      state    <= state_d;
      pc       <= pc_d;
      req_addr <= req_addr_d;
    end
  end

endmodule

// File: tb/tb_ifu_fetch.sv
// Directed self-checking bench for ifu_fetch; memory returns addr ^ 8'hAE after a programmable wait count.
`timescale 1ns/1ps
module tb_ifu_fetch;

  logic       clk = 1'b0;
  logic       rst;
  logic       pc_count, pc_load;
  logic [7:0] load_addr;
  logic       imem_req, imem_ack;
  logic [7:0] imem_addr, imem_rdata, imem_data, pc;
  logic       fetch_valid, stall;

  int waits;
  int wcnt;
  int n_checks;
  int n_fails;

  always #5 clk = ~clk;

  ifu_fetch dut (
    .clk         (clk),
    .rst         (rst),
    .pc_count    (pc_count),
    .pc_load     (pc_load),
    .load_addr   (load_addr),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .imem_data   (imem_data),
    .fetch_valid (fetch_valid),
    .stall       (stall),
    .pc          (pc)
  );

  // Memory model: ack after `waits` idle request cycles.
  always_comb begin
    imem_ack   = imem_req && (wcnt >= waits);
    imem_rdata = imem_addr ^ 8'hAE;
  end

  always_ff @(posedge clk) begin
    if (imem_req && !imem_ack) wcnt <= wcnt + 1;
    else                       wcnt <= 0;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_checks = 0; n_fails = 0; wcnt = 0; waits = 0;
    rst = 1'b0; pc_count = 1'b0; pc_load = 1'b0; load_addr = 8'h00;
    #2;
    // 1: reset values, then zero-wait first fetch
    check("rst_req", 32'(imem_req), 32'd0);
    check("rst_valid", 32'(fetch_valid), 32'd0);
    check("rst_stall", 32'(stall), 32'd1);
    check("rst_pc", 32'(pc), 32'h00);
    check("rst_data", 32'(imem_data), 32'h00);
    step();
    rst = 1'b1;
    #1;
    check("t1_req", 32'(imem_req), 32'd1);
    check("t1_addr", 32'(imem_addr), 32'h00);
    step();
    check("t1_data", 32'(imem_data), 32'hAE);
    check("t1_valid", 32'(fetch_valid), 32'd1);
    check("t1_pc", 32'(pc), 32'h00);

`ifdef IFU_PREFETCH_EN
    // 6: back-to-back pc_count with zero-wait memory, no bubbles
    pc_count = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      step();
      check("t6_valid", 32'(fetch_valid), 32'd1);
      check("t6_pc", 32'(pc), 32'(k));
      check("t6_data", 32'(imem_data), 32'(8'(k) ^ 8'hAE));
    end
    pc_count = 1'b0;
`else
    // 2: two wait states after pc_count
    waits = 2;
    pc_count = 1'b1;
    step();
    pc_count = 1'b0;
    check("t2_pc", 32'(pc), 32'h01);
    for (int k = 0; k < 3; k++) begin
      check("t2_addr_hold", 32'(imem_addr), 32'h01);
      check("t2_req_hold", 32'(imem_req), 32'd1);
      check("t2_stall", 32'(fetch_valid), 32'd0);
      step();
    end
    check("t2_valid", 32'(fetch_valid), 32'd1);
    check("t2_data", 32'(imem_data), 32'hAF);

    // 3: wrap from FF to 00
    waits = 0;
    pc_load = 1'b1; load_addr = 8'hFF;
    step();
    pc_load = 1'b0;
    check("t3_pc_ff", 32'(pc), 32'hFF);
    step();
    check("t3_data_ff", 32'(imem_data), 32'h51);
    pc_count = 1'b1;
    step();
    pc_count = 1'b0;
    check("t3_pc_wrap", 32'(pc), 32'h00);
    check("t3_addr_wrap", 32'(imem_addr), 32'h00);
    step();
    check("t3_data_wrap", 32'(imem_data), 32'hAE);

    // 4a: pc_load beats pc_count in VALID
    pc_load = 1'b1; pc_count = 1'b1; load_addr = 8'h40;
    step();
    pc_load = 1'b0; pc_count = 1'b0;
    check("t4_prio_pc", 32'(pc), 32'h40);
    check("t4_prio_addr", 32'(imem_addr), 32'h40);
    step();
    check("t4_prio_data", 32'(imem_data), 32'hEE);
    // 4b: pc_load in FETCH before ack -> DRAIN, old byte discarded
    waits = 3;
    pc_count = 1'b1;
    step();
    pc_count = 1'b0;
    check("t4_fetch_addr", 32'(imem_addr), 32'h41);
    pc_load = 1'b1; load_addr = 8'h40;
    step();
    pc_load = 1'b0;
    check("t4_drain_pc", 32'(pc), 32'h40);
    check("t4_drain_addr", 32'(imem_addr), 32'h41);
    check("t4_drain_req", 32'(imem_req), 32'd1);
    waits = 0;
    step();
    check("t4_drain_valid", 32'(fetch_valid), 32'd0);
    check("t4_refetch_addr", 32'(imem_addr), 32'h40);
    step();
    check("t4_refetch_data", 32'(imem_data), 32'hEE);
    check("t4_refetch_valid", 32'(fetch_valid), 32'd1);
    // 4c: pc_load coinciding with ack in FETCH
    pc_count = 1'b1;
    step();
    pc_count = 1'b0;
    pc_load = 1'b1; load_addr = 8'h20;
    step();
    pc_load = 1'b0;
    check("t4_ackld_valid", 32'(fetch_valid), 32'd0);
    check("t4_ackld_addr", 32'(imem_addr), 32'h20);
    step();
    check("t4_ackld_data", 32'(imem_data), 32'h8E);
`endif

    // 5: reset mid-request
    waits = 5;
    load_addr = 8'h10; pc_load = 1'b1;
    step();
    pc_load = 1'b0;
    step();
    check("t5_req_before", 32'(imem_req), 32'd1);
    rst = 1'b0;
    #1;
    check("t5_req_rst", 32'(imem_req), 32'd0);
    check("t5_pc_rst", 32'(pc), 32'h00);
    check("t5_valid_rst", 32'(fetch_valid), 32'd0);
    step();
    waits = 0;
    rst = 1'b1;
    #1;
    check("t5_restart_addr", 32'(imem_addr), 32'h00);
    check("t5_restart_req", 32'(imem_req), 32'd1);
    step();
    check("t5_restart_data", 32'(imem_data), 32'hAE);
    check("t5_restart_valid", 32'(fetch_valid), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
